// File: rtl/wc_tile_buffer.sv
// Serial-to-tile feeder for the Winograd core: assembles overlapping N-sample tiles (stride M).
// Optional macro WC_ZERO_PAD_EN prepends R=N-M zero samples to every frame ("same" padding).
module wc_tile_buffer #(
  parameter int W = 10,
  parameter int N = 8,
  parameter int M = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sof,
  input  logic [W-1:0]   in_data,
  output logic           tile_valid,
  input  logic           tile_ready,
  output logic           tile_first,
  output logic [N*W-1:0] D,
  output logic           drop_pulse
);

  localparam int R  = N - M;
  localparam int CW = $clog2(N + 1);
`ifdef WC_ZERO_PAD_EN
  localparam int PRE = R;
`else
  localparam int PRE = 0;
`endif
  localparam logic [CW-1:0] C_PRE = CW'(PRE);
  localparam logic [CW-1:0] C_R   = CW'(R);
  localparam logic [CW-1:0] C_N   = CW'(N);

  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_base;
  logic           r_first;
  logic [N*W-1:0] r_d;
  logic           r_drop;

  logic           w_in_acc;
  logic           w_tile_acc;
  logic [CW-1:0]  w_pending;
  logic [N*W-1:0] w_shift;

  // Lane 0 takes the new sample, every other lane takes its lower neighbour.
  assign w_shift[W-1:0] = in_data;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
      assign w_shift[gi*W +: W] = r_d[(gi-1)*W +: W];
    end
  endgenerate

  assign in_ready   = !rst && (r_cnt < C_N);
  assign tile_valid = (r_cnt == C_N);
  assign tile_first = r_first && tile_valid;
  assign D          = r_d;
  assign drop_pulse = r_drop;

  assign w_in_acc   = in_valid && in_ready;
  assign w_tile_acc = tile_valid && tile_ready;
  // Samples held beyond the overlap carried from the last emitted tile.
  assign w_pending  = r_cnt - r_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= C_PRE;
      r_base  <= C_PRE;
      r_first <= 1'b1;
      r_d     <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_tile_acc) begin
        r_cnt   <= C_R;
        r_base  <= C_R;
        r_first <= 1'b0;
      end else if (w_in_acc) begin
        if (in_sof) begin
          r_drop  <= (w_pending != '0);
          r_d     <= (N*W)'(in_data);
          r_cnt   <= C_PRE + CW'(1);
          r_base  <= C_PRE;
          r_first <= 1'b1;
        end else begin
          r_d   <= w_shift;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wc_tile_buffer.sv
// Testbench for wc_tile_buffer: directed frames then random traffic against a frame-level model.
// The model keeps every sample of the current frame and derives each tile as frame[k*M +: N].
module tb_wc_tile_buffer;

  localparam int W = 10;
  localparam int N = 8;
  localparam int M = 6;
`ifdef WC_ZERO_PAD_EN
  localparam int PRE = N - M;
`else
  localparam int PRE = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_sof = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           tile_valid;
  logic           tile_ready = 1'b0;
  logic           tile_first;
  logic [N*W-1:0] D;
  logic           drop_pulse;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_frame[$];
  int           m_tiles;
  bit           m_drop;

  wc_tile_buffer #(.W(W), .N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_first (tile_first),
    .D          (D),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_frame.delete();
    for (int i = 0; i < PRE; i++) m_frame.push_back('0);
    m_tiles = 0;
    m_drop  = 1'b0;
  endfunction

  function automatic bit model_valid();
    return m_frame.size() >= m_tiles * M + N;
  endfunction

  function automatic logic [N*W-1:0] model_tile();
    logic [N*W-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) t[(N-1-i)*W +: W] = m_frame[m_tiles*M + i];
    return t;
  endfunction

  // Called on a falling edge: checks outputs, drives inputs, advances the model across the next rising edge.
  task automatic step(input bit v, input bit sof, input logic [W-1:0] d, input bit tr);
    bit vld;
    int covered;
    vld = model_valid();
    check("in_ready", {79'd0, in_ready}, {79'd0, !vld});
    check("tile_valid", {79'd0, tile_valid}, {79'd0, vld});
    check("tile_first", {79'd0, tile_first}, {79'd0, vld && (m_tiles == 0)});
    check("drop_pulse", {79'd0, drop_pulse}, {79'd0, m_drop});
    if (vld) check("tile_D", D, model_tile());
    in_valid   = v;
    in_sof     = sof;
    in_data    = d;
    tile_ready = tr;
    m_drop     = 1'b0;
    if (vld && tr) begin
      m_tiles++;
    end else if (!vld && v) begin
      if (sof) begin
        covered = (m_tiles == 0) ? PRE : (m_tiles - 1) * M + N;
        m_drop  = (m_frame.size() > covered);
        m_frame.delete();
        for (int i = 0; i < PRE; i++) m_frame.push_back('0);
        m_tiles = 0;
      end
      m_frame.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    check("rst_in_ready", {79'd0, in_ready}, '0);
    check("rst_tile_valid", {79'd0, tile_valid}, '0);
    check("rst_tile_first", {79'd0, tile_first}, '0);
    check("rst_drop", {79'd0, drop_pulse}, '0);
    check("rst_D", D, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int seq1[8] = '{2, -10, 3, 4, -13, -18, -16, -28};
  int seq2[6] = '{-19, -6, 3, -9, -12, 11};
  logic [N*W-1:0] lit;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

`ifdef WC_ZERO_PAD_EN
    for (int i = 0; i < M; i++) step(1'b1, i == 0, W'(i + 1), 1'b0);
    lit = {10'd0, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
    check("pad_tile_literal", D, lit);
    step(1'b0, 1'b0, '0, 1'b1);
`else
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, W'(seq1[i]), 1'b1);
    lit = 80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100;
    check("tile1_literal", D, lit);
    check("tile1_first", {79'd0, tile_first}, {79'd0, 1'b1});
`endif
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, W'(seq2[i]), 1'b0);
    // Stall with the tile pending: offered samples must be refused.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom), 1'b1);
    step(1'b1, 1'b1, W'($urandom), 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, W'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom), 1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, W'($urandom), 1'b1);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                W'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
